// File: rtl/writeback_port_arbiter.sv
// writeback_port_arbiter: round-robin share of one register-file commit port among writeback units.
// Optional macro WB_ARB_UNIT0_PRIORITY_EN gives unit 0 fixed priority over the round-robin.
module writeback_port_arbiter #(
  parameter int NUM_UNITS   = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int PHYS_ADDR_W = 6,
  parameter int ID_W        = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic [NUM_UNITS-1:0]             unit_done,
  input  logic [NUM_UNITS*PHYS_ADDR_W-1:0] unit_phys_addr,
  input  logic [NUM_UNITS*DATA_WIDTH-1:0]  unit_data,
  input  logic [NUM_UNITS*ID_W-1:0]        unit_id,
  output logic [NUM_UNITS-1:0]             unit_ack,
  output logic                             commit_valid,
  output logic [PHYS_ADDR_W-1:0]           commit_phys_addr,
  output logic [DATA_WIDTH-1:0]            commit_data,
  output logic                             retire_valid,
  output logic [ID_W-1:0]                  retire_id,
  output logic                             inflight_commit,
  output logic [PHYS_ADDR_W-1:0]           inflight_commit_addr
);
  localparam int PW = $clog2(NUM_UNITS);
  logic [NUM_UNITS-1:0] cand;
  logic grant;
  logic [PW-1:0] win, nxt, ptr_q, ptr_d;
  logic [PHYS_ADDR_W-1:0] sel_addr, addr_q, addr_d;
  logic [DATA_WIDTH-1:0] sel_data, data_q, data_d;
  logic [ID_W-1:0] sel_id, id_q, id_d;
  logic commit_valid_q, commit_valid_d, retire_valid_q, retire_valid_d;
  int j;
  // reset also gates candidates so no ack escapes while rst is low
  assign cand = unit_done & ~{NUM_UNITS{flush}} & {NUM_UNITS{rst}};
  always_comb begin
    grant = 1'b0;
    win = '0;
    j = 0;
    for (int i = NUM_UNITS - 1; i >= 0; i--) begin
      j = int'(ptr_q) + i;
      j = (j >= NUM_UNITS) ? j - NUM_UNITS : j;
      if (cand[j]) begin
        grant = 1'b1;
        win = PW'(j);
      end
    end
`ifdef WB_ARB_UNIT0_PRIORITY_EN
    if (cand[0]) begin
      grant = 1'b1;
      win = '0;
    end
`endif
  end
  assign nxt = (win == PW'(NUM_UNITS - 1)) ? '0 : win + 1'b1;
  assign sel_addr = unit_phys_addr[win*PHYS_ADDR_W +: PHYS_ADDR_W];
  assign sel_data = unit_data[win*DATA_WIDTH +: DATA_WIDTH];
  assign sel_id = unit_id[win*ID_W +: ID_W];
  always_comb begin
    unit_ack = '0;
    unit_ack[win] = grant;
  end
  always_comb begin
`ifdef WB_ARB_UNIT0_PRIORITY_EN
    ptr_d = (grant && win != '0) ? nxt : ptr_q;
`else
    ptr_d = grant ? nxt : ptr_q;
`endif
    retire_valid_d = grant;
    commit_valid_d = grant && (sel_addr != '0);
    addr_d = grant ? sel_addr : addr_q;
    data_d = grant ? sel_data : data_q;
    id_d = grant ? sel_id : id_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
      retire_valid_q <= 1'b0;
      commit_valid_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      id_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      retire_valid_q <= retire_valid_d;
      commit_valid_q <= commit_valid_d;
      addr_q <= addr_d;
      data_q <= data_d;
      id_q <= id_d;
    end
  end
  assign commit_valid = commit_valid_q;
  assign commit_phys_addr = addr_q;
  assign commit_data = data_q;
  assign retire_valid = retire_valid_q;
  assign retire_id = id_q;
  assign inflight_commit = commit_valid_q;
  assign inflight_commit_addr = addr_q;
endmodule

// File: tb/tb_writeback_port_arbiter.sv
// tb_writeback_port_arbiter: directed stimulus with a queue scoreboard checked by a separate monitor.
module tb_writeback_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  logic [3:0] unit_done = '0;
  logic [23:0] unit_phys_addr;
  logic [127:0] unit_data;
  logic [11:0] unit_id;
  logic [3:0] unit_ack;
  logic commit_valid, retire_valid, inflight_commit;
  logic [5:0] commit_phys_addr, inflight_commit_addr;
  logic [31:0] commit_data;
  logic [2:0] retire_id;
  logic [5:0] a [4];
  logic [31:0] d [4];
  logic [2:0] id [4];
  typedef struct {logic [2:0] id; logic cv; logic [5:0] a; logic [31:0] d; int c;} pkt_t;
  pkt_t q [$];
  int total = 0, bad = 0, cyc = 0;

  writeback_port_arbiter dut (
    .clk(clk), .rst(rst), .flush(flush), .unit_done(unit_done),
    .unit_phys_addr(unit_phys_addr), .unit_data(unit_data), .unit_id(unit_id),
    .unit_ack(unit_ack), .commit_valid(commit_valid), .commit_phys_addr(commit_phys_addr),
    .commit_data(commit_data), .retire_valid(retire_valid), .retire_id(retire_id),
    .inflight_commit(inflight_commit), .inflight_commit_addr(inflight_commit_addr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    unit_phys_addr = '0;
    unit_data = '0;
    unit_id = '0;
    for (int k = 0; k < 4; k++) begin
      unit_phys_addr[k*6 +: 6] = a[k];
      unit_data[k*32 +: 32] = d[k];
      unit_id[k*3 +: 3] = id[k];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // drive one cycle of requests; the expected ack is hand-computed by the caller
  task automatic step(input logic [3:0] dn, input logic f, input logic [3:0] exp);
    pkt_t p;
    @(negedge clk);
    unit_done = dn;
    flush = f;
    #1;
    chk("ack", {60'd0, unit_ack}, {60'd0, exp});
    for (int k = 0; k < 4; k++)
      if (exp[k]) begin
        p.id = id[k];
        p.cv = (a[k] != 6'd0);
        p.a = a[k];
        p.d = d[k];
        p.c = cyc + 1;
        q.push_back(p);
      end
    @(posedge clk);
    #2;
  endtask

  initial begin : monitor
    pkt_t p;
    forever begin
      @(posedge clk);
      #1;
      if (retire_valid) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_retire: got id %0h expected none", retire_id);
        end else begin
          p = q.pop_front();
          chk("latency", 64'(cyc), 64'(p.c));
          chk("retire_id", {61'd0, retire_id}, {61'd0, p.id});
          chk("commit_valid", {63'd0, commit_valid}, {63'd0, p.cv});
          chk("inflight_commit", {63'd0, inflight_commit}, {63'd0, p.cv});
          chk("commit_addr", {58'd0, commit_phys_addr}, {58'd0, p.a});
          chk("inflight_addr", {58'd0, inflight_commit_addr}, {58'd0, p.a});
          chk("commit_data", {32'd0, commit_data}, {32'd0, p.d});
        end
      end else if (q.size() != 0 && q[0].c <= cyc) begin
        p = q.pop_front();
        chk("missing_retire", 64'(retire_valid), 64'd1);
      end
      if (commit_valid && !retire_valid) chk("commit_without_retire", 64'd1, 64'd0);
    end
  end

  task automatic chk_reset_outputs;
    chk("rst_ack", {60'd0, unit_ack}, 64'd0);
    chk("rst_commit_valid", {63'd0, commit_valid}, 64'd0);
    chk("rst_retire_valid", {63'd0, retire_valid}, 64'd0);
    chk("rst_addr", {58'd0, commit_phys_addr}, 64'd0);
    chk("rst_data", {32'd0, commit_data}, 64'd0);
    chk("rst_id", {61'd0, retire_id}, 64'd0);
    chk("rst_inflight", {57'd0, inflight_commit, inflight_commit_addr}, 64'd0);
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      a[k] = 6'(k + 5);
      d[k] = 32'hA000_0000 + 32'(k);
      id[k] = 3'(k + 1);
    end
    repeat (2) @(posedge clk);
    #2;
    chk_reset_outputs();
    @(negedge clk);
    rst = 1'b1;
    // all four done: plain rotation from ptr 0
    step(4'b1111, 1'b0, 4'b0001);
    step(4'b1110, 1'b0, 4'b0010);
    step(4'b1100, 1'b0, 4'b0100);
    step(4'b1000, 1'b0, 4'b1000);
    step(4'b0000, 1'b0, 4'b0000);
    // unit1 grant puts ptr at 2, then 0011 wraps to unit0 first
    step(4'b0010, 1'b0, 4'b0010);
    a[1] = 6'd9;
    d[1] = 32'h1111_2222;
    id[1] = 3'd6;
    step(4'b0011, 1'b0, 4'b0001);
    step(4'b0010, 1'b0, 4'b0010);
    // address 0 retires without a register write
    a[2] = 6'd0;
    id[2] = 3'd3;
    d[2] = 32'hDEAD_BEEF;
    step(4'b0100, 1'b0, 4'b0100);
    step(4'b0000, 1'b0, 4'b0000);
    // flush holds off the pending unit
    a[2] = 6'd33;
    d[2] = 32'h0000_5A5A;
    id[2] = 3'd7;
    step(4'b0100, 1'b1, 4'b0000);
    step(4'b0100, 1'b1, 4'b0000);
    step(4'b0100, 1'b0, 4'b0100);
    step(4'b0000, 1'b0, 4'b0000);
    // reset while unit1 is on the commit port
    step(4'b0010, 1'b0, 4'b0010);
    rst = 1'b0;
    #1;
    chk_reset_outputs();
    unit_done = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #2;
    // ptr back at 0: unit0 beats unit3
    step(4'b1001, 1'b0, 4'b0001);
    step(4'b1000, 1'b0, 4'b1000);
`ifdef WB_ARB_UNIT0_PRIORITY_EN
    step(4'b1001, 1'b0, 4'b0001);
    step(4'b1001, 1'b0, 4'b0001);
    step(4'b1001, 1'b0, 4'b0001);
    step(4'b1000, 1'b0, 4'b1000);
`endif
    step(4'b0000, 1'b0, 4'b0000);
    step(4'b0000, 1'b0, 4'b0000);
    chk("drain", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/writeback_port_arbiter.md
Name: writeback_port_arbiter

Overview:
- Shares one register-file write (commit) port between NUM_UNITS writeback units that complete out of order.
- Each cycle it picks one completed unit by round-robin and acknowledges it.
- It drives a registered commit packet to the register bank.
- It drives the matching inflight-clear notification (commit flag plus physical address) to the register file's inuse toggle memory, and a retire strobe with the instruction id.
- It sits between the execution units' writeback outputs and one register-file write port.

Parameters:
- NUM_UNITS, 4, number of requesting writeback units (2..8)
- DATA_WIDTH, 32, result data width
- PHYS_ADDR_W, 6, physical register address width (DEPTH = 2**PHYS_ADDR_W)
- ID_W, 3, instruction id width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- flush  in  1  writeback suppress/flush; blocks grants this cycle
- unit_done  in  NUM_UNITS  unit i holds a result
- unit_phys_addr  in  NUM_UNITS*PHYS_ADDR_W  destination physical register per unit
- unit_data  in  NUM_UNITS*DATA_WIDTH  result per unit
- unit_id  in  NUM_UNITS*ID_W  instruction id per unit
- unit_ack  out  NUM_UNITS  one-hot grant, combinational, same cycle as selection
- commit_valid  out  1  register write strobe (never asserted for address 0)
- commit_phys_addr  out  PHYS_ADDR_W  write address
- commit_data  out  DATA_WIDTH  write data
- retire_valid  out  1  instruction completed (includes address 0)
- retire_id  out  ID_W  completed instruction id
- inflight_commit  out  1  inuse-clear toggle, equals commit_valid
- inflight_commit_addr  out  PHYS_ADDR_W  equals commit_phys_addr

Behaviour:
- Reset (rst=0, async):
  - all outputs 0; unit_ack 0.
  - round-robin pointer ptr=0; all registered fields 0.
- Request rules:
  - A unit asserts unit_done with stable addr/data/id.
  - It holds them until the cycle unit_ack[i]=1 and may drop unit_done the following cycle.
  - unit_done without ack must not change addr/data/id.
- Selection (combinational):
  - Candidates are unit_done & ~{NUM_UNITS{flush}}.
  - The winner is the first set candidate scanning ptr, ptr+1, ... NUM_UNITS-1, 0, ... (wrap-around).
  - unit_ack is one-hot for the winner, or zero when there are no candidates.
- Pointer update:
  - On a grant to k, ptr <= (k+1) mod NUM_UNITS.
  - With no grant, ptr holds.
- Output register (1-cycle latency), loaded on the clock edge after the grant:
  - retire_valid <= grant; retire_id <= id_k.
  - commit_valid <= grant & (addr_k != 0).
  - commit_phys_addr/commit_data <= addr_k/data_k.
  - With no grant: retire_valid <= 0, commit_valid <= 0; data/addr hold their last value.
- inflight_commit/inflight_commit_addr are wired directly from commit_valid/commit_phys_addr, so inflight clear and the register write happen in the same cycle.
- Flush:
  - No ack is issued while flush=1.
  - Pending units keep unit_done; the output valids go to 0 on the next edge.
  - Throughput is one grant per cycle; back-to-back grants are allowed.
- Simultaneous: a unit may be acked in cycle n and reassert unit_done with new data in cycle n+1; it competes normally.
- Reset mid-operation: pending requests are discarded by the arbiter (the units are also reset), and no partial commit appears.

Optional Feature:
- WB_ARB_UNIT0_PRIORITY_EN
- Defined:
  - Unit 0 (the single-cycle ALU) wins whenever unit_done[0]=1 and flush=0, regardless of ptr.
  - ptr is not updated on unit-0 grants.
  - Units 1..NUM_UNITS-1 round-robin among themselves when unit 0 is idle.
- Undefined: all units are equal in round-robin as described above.

Test Plan:
- Reset then unit_done=4'b1111, addrs 5,6,7,8 held until ack -> acks in order unit0, 1, 2, 3 on consecutive cycles; commit_phys_addr 5,6,7,8 each one cycle after its ack; commit_valid high 4 cycles.
- ptr=2 (after a unit1 grant), unit_done=4'b0011 -> ack unit0 first (wrap-around), then unit1.
- unit2 done, addr=0, id=3 -> retire_valid=1, retire_id=3, commit_valid=0, inflight_commit=0.
- unit_done=4'b0100 with flush=1 for 2 cycles -> no ack, retire_valid=0; flush drops -> ack unit2 the next cycle, commit the cycle after.
- Assert rst low while unit1 is being committed -> all outputs 0 immediately (async); after release, ptr=0 and unit0 is favoured first.
- WB_ARB_UNIT0_PRIORITY_EN defined, unit0 done every cycle, unit3 done -> unit0 acked every cycle; unit3 acked only when unit0 deasserts.
